exmem_skid_stage: RTL and testbench
===================================

Name: exmem_skid_stage

Overview:
Parametrised successor of the EX/MEM pipeline latch. Carries the EX-stage result bundle (memory/write-back control, ALU result, store data, destination register) into MEM over a valid/ready handshake. A two-entry skid buffer sustains full throughput with a registered ready. Adds flush, debug halt, R0 write suppression and a saturating back-pressure counter.

Parameters:
NB_DATA, 32, width of result and store-data fields
NB_REG, 5, register-index width
NB_WIDTH, 2, memory access-width code width
NB_CNT, 16, width of stall counter

Ports:
clk  in  1  clock, all state updates on rising edge
i_reset  in  1  synchronous reset, active-high
i_halt  in  1  debug halt; freezes all state while high
i_flush  in  1  discard all held entries
i_valid  in  1  EX presents a bundle
o_ready  out  1  stage accepts a bundle this cycle
i_mem2reg  in  1  write-back source is memory
i_memWrite  in  1  store enable
i_regWrite  in  1  register write enable
i_width  in  NB_WIDTH  access width code
i_sign_flag  in  1  sign-extend load
i_result  in  NB_DATA  ALU result / address
i_data4Mem  in  NB_DATA  store data
i_regDst  in  1  1 = destination is rt, 0 = rd
i_rd  in  NB_REG  rd field
i_rt  in  NB_REG  rt field
o_valid  out  1  MEM-side bundle valid
i_ready  in  1  MEM accepts bundle
o_mem2reg, o_memWrite, o_regWrite, o_width, o_sign_flag, o_result, o_data4Mem, o_write_reg  out  as inputs  held bundle
o_stall_cnt  out  NB_CNT  saturating count of back-pressured cycles

Behaviour:
- One clock, clk. Reset i_reset is synchronous, active-high. Reset wins over flush and halt.
- Reset state: main_valid=0, skid_valid=0, data fields 0, o_width=2'b11, o_stall_cnt=0. o_ready=0 during the reset cycle.
- Destination register is resolved at capture: write_reg = i_regDst ? i_rt : i_rd. If write_reg==0, the stored regWrite is 0.
- Combinational signals:
  o_ready = ~skid_valid & ~i_halt & ~i_reset.
  o_valid = main_valid & ~i_halt.
  in_fire = i_valid & o_ready.
  out_fire = o_valid & i_ready.
- o_memWrite and o_regWrite are forced 0 whenever main_valid=0. Other outputs show the main register contents.
- Latency: 1 cycle from in_fire to o_valid when the stage is empty. Throughput is 1 bundle/cycle.
- Transitions, with flush and halt both low:
  - main empty, in_fire: main <= in.
  - main full, out_fire, skid full: main <= skid; skid cleared.
  - main full, out_fire, skid empty, in_fire: main <= in.
  - main full, out_fire, no in_fire: main_valid <= 0.
  - main full, no out_fire, in_fire: skid <= in, so o_ready drops next cycle.
  - skid full: in_fire is impossible, since o_ready=0.
- Flush: main_valid and skid_valid are cleared next cycle. A coincident in_fire is dropped and a coincident out_fire still completes. Flush takes priority over halt; data fields are retained.
- Halt: every register, including o_stall_cnt, holds its value; o_valid and o_ready are low.
- Stall counter: increments when main_valid & ~i_ready & ~i_halt, and saturates at all-ones. It is cleared only by reset.

Optional Feature:
Macro EXMEM_SKID_FWD_EN.
- Defined: adds outputs o_fwd_valid (= main_valid & main regWrite & ~main mem2reg), o_fwd_reg (NB_REG) and o_fwd_data (NB_DATA) for the forwarding unit. These stay valid during halt.
- Undefined: the ports are absent and no extra logic is built.

Decomposition:
- Package exmem_pkg holds:
  - width codes WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b11;
  - WIDTH_RESET=WIDTH_WORD;
  - the packed bundle typedef exmem_bundle_t.
- One natural sub-module: skid_slot, a generic NB_BUNDLE-wide register with load, clear and valid, instantiated twice (main, skid).

Test Plan:
- Reset, then stream 4 bundles (result=0x10..0x13, regDst=0, rd=3) with i_ready=1 -> o_valid from cycle 1; o_result 0x10..0x13 on consecutive cycles; o_write_reg=3; o_stall_cnt=0.
- i_ready=0 for 3 cycles while 2 bundles are sent -> second bundle lands in skid, o_ready=0; then i_ready=1 -> both delivered in order. o_stall_cnt=3.
- regDst=1, rt=0, regWrite=1 -> o_write_reg=0 and o_regWrite=0. Then rt=7 -> o_write_reg=7, o_regWrite=1.
- Main and skid full, assert i_flush with i_valid=1 -> next cycle o_valid=0, o_memWrite=0, o_ready=1; the incoming bundle is not observed.
- i_halt for 5 cycles mid-stream with i_ready=0 -> o_valid=o_ready=0, contents and o_stall_cnt unchanged. Release -> stream resumes with no loss or duplication.
- Assert i_reset while main and skid are full -> next cycle o_valid=0, o_width=2'b11, o_result=0, o_stall_cnt=0.

Source files
------------

// File: rtl/exmem_pkg.sv
// EX/MEM stage shared definitions: access-width codes and the result bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// exmem_bundle_t is the bundle layout at the default widths (32-bit data,
// 5-bit register index, 2-bit width code). The stage re-declares the same
// field order locally so that its parameters can resize the fields.
package exmem_pkg;

  localparam logic [1:0] WIDTH_BYTE  = 2'b00;
  localparam logic [1:0] WIDTH_HALF  = 2'b01;
  localparam logic [1:0] WIDTH_WORD  = 2'b11;
  localparam logic [1:0] WIDTH_RESET = WIDTH_WORD;

  typedef struct packed {
    logic        mem2reg;
    logic        mem_write;
    logic        reg_write;
    logic [1:0]  width;
    logic        sign_flag;
    logic [31:0] result;
    logic [31:0] data4mem;
    logic [4:0]  write_reg;
  } exmem_bundle_t;

endpackage

// File: rtl/exmem_skid_stage_skid_slot.sv
// One bundle register with a valid flag; load wins over clear.
// Latency: 1 cycle from i_load to o_valid/o_dat.
// Backpressure: none internally; i_en low freezes the slot.
//
// Ports: clk, i_reset (sync, active-high), i_en (update enable),
//        i_load / i_clear (load i_dat and set valid / drop valid),
//        i_dat (bundle in), o_dat / o_valid (held bundle and its valid).
//        Clearing keeps the data bits; only the valid flag drops.
module skid_slot #(
  parameter int                   NB_BUNDLE = 8,
  parameter logic [NB_BUNDLE-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_en,
  input  logic                 i_load,
  input  logic                 i_clear,
  input  logic [NB_BUNDLE-1:0] i_dat,
  output logic [NB_BUNDLE-1:0] o_dat,
  output logic                 o_valid
);

  logic [NB_BUNDLE-1:0] r_dat;
  logic                 r_valid;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_dat   <= RESET_VAL;
      r_valid <= 1'b0;
    end else if (i_en) begin
      if (i_load) begin
        r_dat   <= i_dat;
        r_valid <= 1'b1;
      end else if (i_clear) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_dat   = r_dat;
  assign o_valid = r_valid;

endmodule

// File: rtl/exmem_skid_stage.sv
// EX->MEM pipeline stage: two-entry skid buffer carrying the EX result bundle.
// Latency: 1 cycle from accept to o_valid when empty; 1 bundle/cycle sustained.
// Backpressure: o_ready is ~skid_valid (registered), so one extra bundle is absorbed.
//
// Ports: clk, i_reset (sync, active-high), i_halt (freeze), i_flush (drop all),
//        EX side i_valid/o_ready + bundle fields, MEM side o_valid/i_ready +
//        held bundle, o_stall_cnt (saturating count of back-pressured cycles).
// Optional: `define EXMEM_SKID_FWD_EN adds o_fwd_valid/o_fwd_reg/o_fwd_data.
module exmem_skid_stage
  import exmem_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter int NB_WIDTH = 2,
  parameter int NB_CNT   = 16
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_halt,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_mem2reg,
  input  logic                i_memWrite,
  input  logic                i_regWrite,
  input  logic [NB_WIDTH-1:0] i_width,
  input  logic                i_sign_flag,
  input  logic [NB_DATA-1:0]  i_result,
  input  logic [NB_DATA-1:0]  i_data4Mem,
  input  logic                i_regDst,
  input  logic [NB_REG-1:0]   i_rd,
  input  logic [NB_REG-1:0]   i_rt,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_mem2reg,
  output logic                o_memWrite,
  output logic                o_regWrite,
  output logic [NB_WIDTH-1:0] o_width,
  output logic                o_sign_flag,
  output logic [NB_DATA-1:0]  o_result,
  output logic [NB_DATA-1:0]  o_data4Mem,
  output logic [NB_REG-1:0]   o_write_reg,
`ifdef EXMEM_SKID_FWD_EN
  output logic                o_fwd_valid,
  output logic [NB_REG-1:0]   o_fwd_reg,
  output logic [NB_DATA-1:0]  o_fwd_data,
`endif
  output logic [NB_CNT-1:0]   o_stall_cnt
);

  typedef struct packed {
    logic                mem2reg;
    logic                mem_write;
    logic                reg_write;
    logic [NB_WIDTH-1:0] width;
    logic                sign_flag;
    logic [NB_DATA-1:0]  result;
    logic [NB_DATA-1:0]  data4mem;
    logic [NB_REG-1:0]   write_reg;
  } bundle_t;

  localparam int      NB_BUNDLE  = $bits(bundle_t);
  localparam bundle_t RST_BUNDLE = '{
    mem2reg:   1'b0,
    mem_write: 1'b0,
    reg_write: 1'b0,
    width:     NB_WIDTH'(WIDTH_RESET),
    sign_flag: 1'b0,
    result:    '0,
    data4mem:  '0,
    write_reg: '0
  };

  bundle_t           w_in, w_main, w_skid, w_main_nxt;
  logic              w_main_vld, w_skid_vld;
  logic              w_in_fire, w_out_fire;
  logic              w_en;
  logic              w_main_load, w_main_clear, w_skid_load, w_skid_clear;
  logic [NB_REG-1:0] w_write_reg;
  logic [NB_CNT-1:0] r_stall_cnt;

  // Destination is resolved at capture; a write to R0 is squashed here so
  // MEM/WB never see it as a real register write.
  assign w_write_reg = i_regDst ? i_rt : i_rd;
  always_comb begin
    w_in           = RST_BUNDLE;
    w_in.mem2reg   = i_mem2reg;
    w_in.mem_write = i_memWrite;
    w_in.reg_write = i_regWrite & (w_write_reg != '0);
    w_in.width     = i_width;
    w_in.sign_flag = i_sign_flag;
    w_in.result    = i_result;
    w_in.data4mem  = i_data4Mem;
    w_in.write_reg = w_write_reg;
  end

  assign o_ready    = ~w_skid_vld & ~i_halt & ~i_reset;
  assign o_valid    = w_main_vld & ~i_halt;
  assign w_in_fire  = i_valid & o_ready;
  assign w_out_fire = o_valid & i_ready;

  // Flush must still clear the valids while halted; otherwise halt freezes.
  // Loads are gated by flush so a coincident incoming bundle is dropped.
  assign w_en         = ~i_halt | i_flush;
  assign w_main_load  = ~i_flush & ((~w_main_vld & w_in_fire) |
                                    (w_main_vld & w_out_fire & (w_skid_vld | w_in_fire)));
  assign w_main_clear = i_flush | (w_main_vld & w_out_fire & ~w_skid_vld & ~w_in_fire);
  assign w_skid_load  = ~i_flush & w_main_vld & ~w_out_fire & w_in_fire;
  assign w_skid_clear = i_flush | (w_main_vld & w_out_fire & w_skid_vld);
  assign w_main_nxt   = w_skid_vld ? w_skid : w_in;

  skid_slot #(.NB_BUNDLE(NB_BUNDLE), .RESET_VAL(RST_BUNDLE)) u_main (
    .clk     (clk),
    .i_reset (i_reset),
    .i_en    (w_en),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_dat   (w_main_nxt),
    .o_dat   (w_main),
    .o_valid (w_main_vld)
  );

  skid_slot #(.NB_BUNDLE(NB_BUNDLE), .RESET_VAL(RST_BUNDLE)) u_skid (
    .clk     (clk),
    .i_reset (i_reset),
    .i_en    (w_en),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_dat   (w_in),
    .o_dat   (w_skid),
    .o_valid (w_skid_vld)
  );

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
    end else if (w_main_vld & ~i_ready & ~i_halt & ~(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + NB_CNT'(1);
    end
  end

  // Side-effecting controls are masked when nothing is held; data fields
  // simply show whatever the main slot last contained.
  assign o_mem2reg   = w_main.mem2reg;
  assign o_memWrite  = w_main_vld & w_main.mem_write;
  assign o_regWrite  = w_main_vld & w_main.reg_write;
  assign o_width     = w_main.width;
  assign o_sign_flag = w_main.sign_flag;
  assign o_result    = w_main.result;
  assign o_data4Mem  = w_main.data4mem;
  assign o_write_reg = w_main.write_reg;
  assign o_stall_cnt = r_stall_cnt;

`ifdef EXMEM_SKID_FWD_EN
  // Forwarding view ignores halt: the held value is still architecturally next.
  assign o_fwd_valid = w_main_vld & w_main.reg_write & ~w_main.mem2reg;
  assign o_fwd_reg   = w_main.write_reg;
  assign o_fwd_data  = w_main.result;
`endif

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Randomized + directed bench for exmem_skid_stage against a queue model.
// Latency: model holds up to two bundles; head is what MEM sees.
// Backpressure: model ready is "fewer than two held", never halted or in reset.
module tb_exmem_skid_stage;
  import exmem_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset, i_halt, i_flush, i_valid, i_ready;
  logic        i_mem2reg, i_memWrite, i_regWrite, i_sign_flag, i_regDst;
  logic [1:0]  i_width;
  logic [31:0] i_result, i_data4Mem;
  logic [4:0]  i_rd, i_rt;
  logic        o_ready, o_valid, o_mem2reg, o_memWrite, o_regWrite, o_sign_flag;
  logic [1:0]  o_width;
  logic [31:0] o_result, o_data4Mem;
  logic [4:0]  o_write_reg;
  logic [15:0] o_stall_cnt;
`ifdef EXMEM_SKID_FWD_EN
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_reg;
  logic [31:0] o_fwd_data;
`endif

  always #5 clk = ~clk;

  exmem_skid_stage dut (
    .clk(clk), .i_reset(i_reset), .i_halt(i_halt), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_mem2reg(i_mem2reg), .i_memWrite(i_memWrite), .i_regWrite(i_regWrite),
    .i_width(i_width), .i_sign_flag(i_sign_flag), .i_result(i_result),
    .i_data4Mem(i_data4Mem), .i_regDst(i_regDst), .i_rd(i_rd), .i_rt(i_rt),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_mem2reg(o_mem2reg), .o_memWrite(o_memWrite), .o_regWrite(o_regWrite),
    .o_width(o_width), .o_sign_flag(o_sign_flag), .o_result(o_result),
    .o_data4Mem(o_data4Mem), .o_write_reg(o_write_reg),
`ifdef EXMEM_SKID_FWD_EN
    .o_fwd_valid(o_fwd_valid), .o_fwd_reg(o_fwd_reg), .o_fwd_data(o_fwd_data),
`endif
    .o_stall_cnt(o_stall_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of held bundles, plus what the main
  // register last held (shown on the data outputs when nothing is valid).
  exmem_bundle_t q[$];
  exmem_bundle_t last_main;
  exmem_bundle_t rst_b;
  int unsigned   cnt;

  function automatic exmem_bundle_t capture();
    exmem_bundle_t b;
    b.mem2reg   = i_mem2reg;
    b.mem_write = i_memWrite;
    b.width     = i_width;
    b.sign_flag = i_sign_flag;
    b.result    = i_result;
    b.data4mem  = i_data4Mem;
    b.write_reg = i_regDst ? i_rt : i_rd;
    b.reg_write = i_regWrite && (b.write_reg != 5'd0);
    return b;
  endfunction

  task automatic cycle();
    exmem_bundle_t shown, nb;
    logic m_rdy, m_vld, in_f, out_f, held;
    @(negedge clk);
    held  = q.size() > 0;
    m_rdy = (q.size() < 2) && !i_halt && !i_reset;
    m_vld = held && !i_halt;
    shown = held ? q[0] : last_main;
    chk("o_ready",     64'(o_ready),     64'(m_rdy));
    chk("o_valid",     64'(o_valid),     64'(m_vld));
    chk("o_result",    64'(o_result),    64'(shown.result));
    chk("o_data4Mem",  64'(o_data4Mem),  64'(shown.data4mem));
    chk("o_write_reg", 64'(o_write_reg), 64'(shown.write_reg));
    chk("o_width",     64'(o_width),     64'(shown.width));
    chk("o_sign_flag", 64'(o_sign_flag), 64'(shown.sign_flag));
    chk("o_mem2reg",   64'(o_mem2reg),   64'(shown.mem2reg));
    chk("o_memWrite",  64'(o_memWrite),  64'(held && shown.mem_write));
    chk("o_regWrite",  64'(o_regWrite),  64'(held && shown.reg_write));
    chk("o_stall_cnt", 64'(o_stall_cnt), 64'(cnt));
    in_f  = i_valid && m_rdy;
    out_f = m_vld && i_ready;
    nb    = capture();
    @(posedge clk);
    if (i_reset) begin
      q.delete();
      last_main = rst_b;
      cnt = 0;
    end else begin
      if (held && !i_ready && !i_halt && cnt != 32'hFFFF) cnt++;
      if (i_flush) q.delete();
      else begin
        if (out_f) void'(q.pop_front());
        if (in_f) q.push_back(nb);
        if (q.size() > 0) last_main = q[0];
      end
    end
    #1;
  endtask

  task automatic set_bundle(input logic [31:0] res, input logic dst,
                            input logic [4:0] rd, input logic [4:0] rt, input logic rw);
    i_result = res; i_data4Mem = ~res; i_regDst = dst; i_rd = rd; i_rt = rt;
    i_regWrite = rw; i_memWrite = res[0]; i_mem2reg = res[1];
    i_sign_flag = res[2]; i_width = res[4:3];
  endtask

  task automatic do_reset();
    i_reset = 1'b1; cycle(); i_reset = 1'b0;
  endtask

  initial begin
    rst_b = '0;
    rst_b.width = WIDTH_RESET;
    i_reset = 1'b1; i_halt = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    set_bundle(32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
    @(posedge clk); #1;
    q.delete(); last_main = rst_b; cnt = 0;
    do_reset();
    chk("rst_width",  64'(o_width),     64'h3);
    chk("rst_result", 64'(o_result),    64'h0);
    chk("rst_valid",  64'(o_valid),     64'h0);

    // Back-to-back stream, always accepted downstream.
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; set_bundle(32'h10 + k, 1'b0, 5'd3, 5'd9, 1'b1); cycle();
    end
    i_valid = 1'b0; cycle(); cycle();

    // Downstream stall: second bundle parks in the skid, then both drain.
    do_reset();
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; set_bundle(32'h20 + k, 1'b0, 5'd4, 5'd0, 1'b1); cycle();
    end
    chk("stall3", 64'(o_stall_cnt), 64'd3);
    i_valid = 1'b0; i_ready = 1'b1; cycle(); cycle(); cycle();

    // R0 write suppression, then a real destination.
    i_valid = 1'b1; set_bundle(32'h30, 1'b1, 5'd5, 5'd0, 1'b1); cycle();
    set_bundle(32'h31, 1'b1, 5'd5, 5'd7, 1'b1); cycle();
    i_valid = 1'b0; cycle();
    chk("rt7_reg", 64'(o_write_reg), 64'd7);

    // Fill both entries, then flush with a coincident incoming bundle.
    i_ready = 1'b0; i_valid = 1'b1;
    set_bundle(32'h40, 1'b0, 5'd1, 5'd0, 1'b1); cycle();
    set_bundle(32'h41, 1'b0, 5'd2, 5'd0, 1'b1); cycle();
    i_flush = 1'b1; set_bundle(32'h42, 1'b0, 5'd3, 5'd0, 1'b1); cycle();
    i_flush = 1'b0; i_valid = 1'b0; cycle();
    chk("flush_valid", 64'(o_valid), 64'h0);

    // Halt mid-stream under back-pressure, then resume.
    i_valid = 1'b1; set_bundle(32'h50, 1'b0, 5'd6, 5'd0, 1'b1); cycle();
    set_bundle(32'h51, 1'b0, 5'd6, 5'd0, 1'b1); cycle();
    i_halt = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    i_halt = 1'b0; i_valid = 1'b0; i_ready = 1'b1; cycle(); cycle(); cycle();

    // Reset while both entries are full.
    i_ready = 1'b0; i_valid = 1'b1;
    set_bundle(32'h60, 1'b0, 5'd8, 5'd0, 1'b1); cycle();
    set_bundle(32'h61, 1'b0, 5'd8, 5'd0, 1'b1); cycle();
    i_valid = 1'b0; do_reset();
    chk("rst2_valid",  64'(o_valid),     64'h0);
    chk("rst2_width",  64'(o_width),     64'h3);
    chk("rst2_result", 64'(o_result),    64'h0);
    chk("rst2_cnt",    64'(o_stall_cnt), 64'h0);

    // Randomized traffic with occasional halt/flush/reset.
    i_ready = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 2) != 0);
      i_halt  = ($urandom_range(0, 15) == 0);
      i_flush = ($urandom_range(0, 31) == 0);
      i_reset = ($urandom_range(0, 199) == 0);
      set_bundle($urandom, 1'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                 5'($urandom), 1'($urandom));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
